// File: rtl/gpio_input_conditioner.sv
// Per-pin synchroniser, debouncer and edge detector feeding a prioritised event FIFO.
// Accepted transitions appear both as level/pulse vectors and as a serial event stream.
module gpio_input_conditioner #(
  parameter int WIDTH      = 8,
  parameter int DB_CYCLES  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [WIDTH-1:0]         pin_in,
  output logic [WIDTH-1:0]         level_out,
  output logic [WIDTH-1:0]         rise_pulse,
  output logic [WIDTH-1:0]         fall_pulse,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(WIDTH)-1:0] evt_pin,
  output logic                     evt_rise,
  output logic                     overflow
);

  localparam int PW = $clog2(WIDTH);
  localparam int CW = $clog2(DB_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] r_sync1, r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_rise, r_fall;
  logic [WIDTH-1:0] r_pend, r_pend_dir;
  logic             r_overflow;

  logic [PW:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;

  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_push_oh;
  logic [PW-1:0]    w_arb_idx;
  logic             w_full, w_push, w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pin_in;
      r_sync2 <= r_sync1;
    end
  end

  // A pin is accepted on the cycle its mismatch has persisted DB_CYCLES samples.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_accept[i] = en && (r_sync2[i] != r_stable[i]) &&
                    (r_cnt[i] == CW'(DB_CYCLES - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_stable <= r_stable ^ w_accept;
      r_rise   <= w_accept & r_sync2;
      r_fall   <= w_accept & ~r_sync2;
      for (int i = 0; i < WIDTH; i++) begin
        if (!en || (r_sync2[i] == r_stable[i]) || w_accept[i]) r_cnt[i] <= '0;
        else r_cnt[i] <= r_cnt[i] + CW'(1);
      end
    end
  end

  // Fullness is judged on the registered count, so a pop never frees a slot in the same cycle.
  always_comb begin
    w_arb_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (r_pend[i]) w_arb_idx = PW'(i);
    end
  end

  assign w_full    = (r_count == (AW + 1)'(FIFO_DEPTH));
  assign w_push    = en && !w_full && (|r_pend);
  assign w_push_oh = w_push ? (WIDTH'(1) << w_arb_idx) : '0;
  assign w_pop     = (r_count != '0) && evt_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend     <= '0;
      r_pend_dir <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pend     <= (r_pend & ~w_push_oh) | w_accept;
      r_pend_dir <= (r_pend_dir & ~w_accept) | (w_accept & r_sync2);
      if (|(w_accept & r_pend & ~w_push_oh)) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {w_arb_idx, r_pend_dir[w_arb_idx]};
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign level_out  = r_stable;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign overflow   = r_overflow;
  assign evt_valid  = (r_count != '0);
  assign evt_pin    = r_mem[r_rptr][PW:1];
  assign evt_rise   = r_mem[r_rptr][0];

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Bench for gpio_input_conditioner: directed scenarios plus random traffic,
// all checked against a sample-history / queue model of the conditioner.
module tb_gpio_input_conditioner;
  localparam int W  = 8;
  localparam int DB = 16;
  localparam int FD = 4;

  typedef struct packed {
    logic [2:0] pin;
    logic       rise;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst, en, evt_ready;
  logic [W-1:0] pin_in;
  logic [W-1:0] level_out, rise_pulse, fall_pulse;
  logic         evt_valid, evt_rise, overflow;
  logic [2:0]   evt_pin;

  int n_cmp = 0;
  int n_bad = 0;

  gpio_input_conditioner #(.WIDTH(W), .DB_CYCLES(DB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .en(en), .pin_in(pin_in),
    .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_pin(evt_pin),
    .evt_rise(evt_rise), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Model: a pin is accepted once its last DB synchronised samples, all taken with en high,
  // disagree with the current debounced level.
  logic [W-1:0] m_s1, m_s2, m_level, m_rise, m_fall, m_pend, m_pdir;
  logic         m_ovf;
  logic [W-1:0] hq[$];
  bit           eq[$];
  ev_t          mq[$];

  task automatic model_step();
    logic [W-1:0] acc;
    bit pop, full, pushed, ok;
    int p;
    ev_t e;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0;
      m_pend = '0; m_pdir = '0; m_ovf = 1'b0;
      hq.delete(); eq.delete(); mq.delete();
      return;
    end
    pop  = (mq.size() > 0) && evt_ready;
    full = (mq.size() == FD);
    hq.push_back(m_s2);
    eq.push_back(en);
    if (hq.size() > DB) begin
      void'(hq.pop_front());
      void'(eq.pop_front());
    end
    acc = '0;
    if (hq.size() == DB) begin
      for (int i = 0; i < W; i++) begin
        ok = 1;
        for (int k = 0; k < DB; k++) if (!eq[k] || hq[k][i] == m_level[i]) ok = 0;
        acc[i] = ok;
      end
    end
    pushed = 0; p = 0; e = '0;
    if (en && !full)
      for (int i = W - 1; i >= 0; i--) if (m_pend[i]) begin pushed = 1; p = i; end
    for (int i = 0; i < W; i++)
      if (acc[i] && m_pend[i] && !(pushed && p == i)) m_ovf = 1'b1;
    if (pushed) begin
      e.pin  = 3'(p);
      e.rise = m_pdir[p];
      m_pend[p] = 1'b0;
    end
    for (int i = 0; i < W; i++)
      if (acc[i]) begin m_pend[i] = 1'b1; m_pdir[i] = m_s2[i]; end
    m_rise  = acc & m_s2;
    m_fall  = acc & ~m_s2;
    m_level = m_level ^ acc;
    if (pop) void'(mq.pop_front());
    if (pushed) mq.push_back(e);
    m_s2 = m_s1;
    m_s1 = pin_in;
  endtask

  function automatic logic [29:0] dut_vec();
    return {level_out, rise_pulse, fall_pulse, evt_valid,
            evt_valid ? evt_pin : 3'd0, evt_valid ? evt_rise : 1'b0, overflow};
  endfunction

  function automatic logic [29:0] model_vec();
    ev_t h;
    h = (mq.size() > 0) ? mq[0] : '0;
    return {m_level, m_rise, m_fall, mq.size() > 0, h.pin, h.rise, m_ovf};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; evt_ready = 1'b1; pin_in = '0;
    tick(); tick();
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    int first;
    rst = 1'b1; en = 1'b1; evt_ready = 1'b1; pin_in = 8'hFF;
    repeat (2) begin
      tick();
      n_cmp++;
      if ({dut_vec(), evt_pin, evt_rise} !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs dut=%h required=0", {dut_vec(), evt_pin, evt_rise});
      end
    end
    rst = 1'b0;
    first = -1;
    for (int k = 0; k < 30; k++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL reset_model k=%0d dut=%h model=%h", k, dut_vec(), model_vec());
      end
      if (first < 0 && level_out == 8'hFF) first = k;
      if (k == 17) begin
        n_cmp++;
        if (rise_pulse !== 8'hFF) begin
          n_bad++;
          $display("FAIL powerup_rise got=%h required=ff", rise_pulse);
        end
      end
      if (k >= 18 && k <= 25) begin
        n_cmp++;
        if (!evt_valid || evt_pin !== 3'(k - 18) || evt_rise !== 1'b1) begin
          n_bad++;
          $display("FAIL powerup_evt k=%0d got v=%b pin=%0d r=%b required pin=%0d rise", k,
                   evt_valid, evt_pin, evt_rise, k - 18);
        end
      end
    end
    n_cmp++;
    if (first !== 17) begin
      n_bad++;
      $display("FAIL powerup_latency got=%0d required=17", first);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int seg = 0; seg < 8; seg++) begin
      pin_in[3] = (seg % 2 == 0);
      repeat (5) begin
        tick();
        n_cmp++;
        if (dut_vec() !== model_vec() || rise_pulse[3] || fall_pulse[3] || evt_valid) begin
          n_bad++;
          $display("FAIL bounce_quiet dut=%h model=%h", dut_vec(), model_vec());
        end
      end
    end
    pin_in[3] = 1'b1;
    for (int k = 0; k < 18; k++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== model_vec() || level_out[3] !== (k == 17) ||
          rise_pulse[3] !== (k == 17)) begin
        n_bad++;
        $display("FAIL bounce_accept k=%0d lvl=%b rise=%b required=%b dut=%h model=%h", k,
                 level_out[3], rise_pulse[3], k == 17, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_simultaneous();
    ev_t got[$];
    int  at[$];
    do_reset();
    pin_in = 8'b0100_0010;
    for (int k = 0; k < 25; k++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL simul_model k=%0d dut=%h model=%h", k, dut_vec(), model_vec());
      end
      if (evt_valid && evt_ready) begin got.push_back({evt_pin, evt_rise}); at.push_back(k); end
    end
    n_cmp++;
    if (got.size() != 2 || got[0] !== {3'd1, 1'b1} || got[1] !== {3'd6, 1'b1} ||
        at[1] != at[0] + 1 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL simul_order got n=%0d ovf=%b required (1,R),(6,R) back-to-back ovf=0",
               got.size(), overflow);
    end
  endtask

  task automatic test_backpressure();
    ev_t got[$];
    ev_t exp_ev[6];
    exp_ev = '{{3'd0, 1'b1}, {3'd1, 1'b1}, {3'd2, 1'b1}, {3'd3, 1'b1}, {3'd4, 1'b0}, {3'd5, 1'b1}};
    do_reset();
    evt_ready = 1'b0;
    pin_in = 8'h3F;
    repeat (25) begin
      tick();
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL bp_fill dut=%h model=%h", dut_vec(), model_vec());
      end
    end
    n_cmp++;
    if (!evt_valid || evt_pin !== 3'd0 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_full got v=%b pin=%0d ovf=%b required v=1 pin=0 ovf=0",
               evt_valid, evt_pin, overflow);
    end
    pin_in = 8'h2F;
    repeat (22) tick();
    n_cmp++;
    if (overflow !== 1'b1 || dut_vec() !== model_vec()) begin
      n_bad++;
      $display("FAIL bp_overflow got=%b required=1", overflow);
    end
    evt_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (evt_valid) got.push_back({evt_pin, evt_rise});
      tick();
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL bp_drain dut=%h model=%h", dut_vec(), model_vec());
      end
    end
    n_cmp++;
    if (got.size() != 6) begin
      n_bad++;
      $display("FAIL bp_count got=%0d required=6", got.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (got[i] !== exp_ev[i]) begin
          n_bad++;
          $display("FAIL bp_event i=%0d got=%h required=%h", i, got[i], exp_ev[i]);
        end
      end
    end
  endtask

  task automatic test_enable();
    do_reset();
    en = 1'b0;
    pin_in = 8'h04;
    repeat (40) begin
      tick();
      n_cmp++;
      if (dut_vec() !== model_vec() || level_out !== 8'h00 || evt_valid || rise_pulse !== 8'h00) begin
        n_bad++;
        $display("FAIL en_gated lvl=%h v=%b rise=%h required 00/0/00", level_out, evt_valid, rise_pulse);
      end
    end
    en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== model_vec() || level_out[2] !== (k == 16)) begin
        n_bad++;
        $display("FAIL en_resume k=%0d lvl2=%b required=%b", k, level_out[2], k == 16);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    evt_ready = 1'b0;
    pin_in = 8'h3F;
    repeat (25) tick();
    pin_in = 8'h2F;
    repeat (22) tick();
    n_cmp++;
    if (!evt_valid || overflow !== 1'b1 || dut_vec() !== model_vec()) begin
      n_bad++;
      $display("FAIL mid_setup v=%b ovf=%b required 1/1", evt_valid, overflow);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (evt_valid !== 1'b0 || overflow !== 1'b0 || level_out !== 8'h00) begin
      n_bad++;
      $display("FAIL mid_reset v=%b ovf=%b lvl=%h required 0/0/00", evt_valid, overflow, level_out);
    end
    repeat (10) begin
      tick();
      n_cmp++;
      if (dut_vec() !== model_vec() || evt_valid) begin
        n_bad++;
        $display("FAIL mid_after dut=%h model=%h", dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_random();
    int rp;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      case ((c / 500) % 3)
        0:       rp = 90;
        1:       rp = 10;
        default: rp = 50;
      endcase
      for (int i = 0; i < W; i++) if ($urandom_range(31) == 0) pin_in[i] = ~pin_in[i];
      evt_ready = ($urandom_range(99) < rp);
      if ($urandom_range(199) == 0) en = ~en;
      rst = ($urandom_range(999) == 0);
      tick();
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL random c=%0d dut=%h model=%h", c, dut_vec(), model_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; evt_ready = 1'b1; pin_in = '0;
    test_reset();
    test_bounce();
    test_simultaneous();
    test_backpressure();
    test_enable();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
